// File: rtl/vigna_arb_pkg.sv
// Shared types and the grant-selection helper for the vigna instruction/data memory-port arbiter.
package vigna_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2,
    ARB_TURN  = 2'd3
  } arb_state_t;

  localparam logic ARB_OWN_I = 1'b0;
  localparam logic ARB_OWN_D = 1'b1;

  // On contention, round-robin hands the port to whoever did not own it last;
  // fixed priority always favours the data port.
  function automatic arb_state_t arb_pick(input logic i_req, input logic d_req,
                                          input logic round_robin, input logic last_gnt);
    arb_state_t pick;
    pick = ARB_IDLE;
    if (i_req && d_req) begin
      pick = (round_robin && (last_gnt == ARB_OWN_D)) ? ARB_GNT_I : ARB_GNT_D;
    end else if (i_req) begin
      pick = ARB_GNT_I;
    end else if (d_req) begin
      pick = ARB_GNT_D;
    end
    return pick;
  endfunction

endpackage

// File: rtl/vigna_bus_arbiter_if.sv
// Bundle of the instruction, data and shared memory port signals around the arbiter.
interface vigna_bus_arbiter_if;

  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;

  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic [31:0] d_rdata;

  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;

  // Arbiter side.
  modport master (
    input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, m_ready, m_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, m_valid, m_addr, m_wdata, m_wstrb
  );

  // Environment side: core ports and memory.
  modport slave (
    output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, m_ready, m_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, m_valid, m_addr, m_wdata, m_wstrb
  );

endinterface

// File: rtl/vigna_bus_arbiter.sv
// Two-to-one arbiter sharing one memory port between the vigna instruction and data ports,
// with a one-cycle turnaround after every completed transfer.
module vigna_bus_arbiter
  import vigna_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input logic                 clk,
  input logic                 resetn,
  vigna_bus_arbiter_if.master bus
);

  arb_state_t state_q, state_d;
  logic       last_gnt_q, last_gnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= ARB_OWN_I;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    bus.m_valid = 1'b0;
    bus.m_addr  = 32'h0;
    bus.m_wdata = 32'h0;
    bus.m_wstrb = 4'h0;
    bus.i_ready = 1'b0;
    bus.d_ready = 1'b0;

    unique case (state_q)
      ARB_IDLE, ARB_TURN: begin
        // Memory ready here is deliberately ignored: sticky slaves may still be high.
        state_d = arb_pick(bus.i_valid, bus.d_valid, ROUND_ROBIN, last_gnt_q);
        if (state_d == ARB_GNT_I) last_gnt_d = ARB_OWN_I;
        if (state_d == ARB_GNT_D) last_gnt_d = ARB_OWN_D;
      end
      ARB_GNT_I: begin
        // Instruction port is read-only, so write data and strobes stay zero.
        bus.m_valid = 1'b1;
        bus.m_addr  = bus.i_addr;
        bus.i_ready = bus.m_ready;
        if (bus.m_ready) state_d = ARB_TURN;
      end
      ARB_GNT_D: begin
        bus.m_valid = 1'b1;
        bus.m_addr  = bus.d_addr;
        bus.m_wdata = bus.d_wdata;
        bus.m_wstrb = bus.d_wstrb;
        bus.d_ready = bus.m_ready;
        if (bus.m_ready) state_d = ARB_TURN;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Directed bench for vigna_bus_arbiter: cycle-by-cycle vector table plus memory-backed sequences.
module tb_vigna_bus_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Shared core-side stimulus
  logic        i_valid = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_valid = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  // Slave mode: 0 = table driven, 1 = one-cycle memory, 2 = ready held until valid drops
  int          mode = 0;
  logic        tb_m_ready = 1'b0;
  logic [31:0] tb_m_rdata = '0;

  int n_checks = 0;
  int n_fail = 0;

  vigna_bus_arbiter_if bus ();
  vigna_bus_arbiter_if bus_fp ();

  vigna_bus_arbiter #(.ROUND_ROBIN(1'b1)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  vigna_bus_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (.clk(clk), .resetn(resetn), .bus(bus_fp));

  logic [31:0] mem [16];
  logic        ready_q;
  logic        fp_ready_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 16; k++) mem[k] <= {16'hA5A5, 16'(k * 4)};
      ready_q    <= 1'b0;
      fp_ready_q <= 1'b0;
    end else begin
      ready_q    <= (mode == 2) ? bus.m_valid : (bus.m_valid && !ready_q);
      fp_ready_q <= bus_fp.m_valid && !fp_ready_q;
      if (mode != 0 && bus.m_valid && bus.m_ready) begin
        for (int b = 0; b < 4; b++)
          if (bus.m_wstrb[b]) mem[bus.m_addr[5:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
      end
    end
  end

  assign bus.i_valid = i_valid;
  assign bus.i_addr  = i_addr;
  assign bus.d_valid = d_valid;
  assign bus.d_addr  = d_addr;
  assign bus.d_wdata = d_wdata;
  assign bus.d_wstrb = d_wstrb;
  assign bus.m_ready = (mode == 0) ? tb_m_ready : ready_q;
  assign bus.m_rdata = (mode == 0) ? tb_m_rdata : mem[bus.m_addr[5:2]];

  assign bus_fp.i_valid = i_valid;
  assign bus_fp.i_addr  = i_addr;
  assign bus_fp.d_valid = d_valid;
  assign bus_fp.d_addr  = d_addr;
  assign bus_fp.d_wdata = d_wdata;
  assign bus_fp.d_wstrb = d_wstrb;
  assign bus_fp.m_ready = fp_ready_q;
  assign bus_fp.m_rdata = 32'h0;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [31:0] dw;
    logic [3:0]  ds;
    logic        mr;
    logic [31:0] mrd;
    logic        e_mv;
    logic [31:0] e_ma;
    logic [31:0] e_mw;
    logic [3:0]  e_ms;
    logic        e_ir;
    logic        e_dr;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] outs();
    return {bus.m_valid, bus.m_addr, bus.m_wdata, bus.m_wstrb, bus.i_ready, bus.d_ready};
  endfunction

  task automatic do_reset();
    resetn  = 1'b0;
    i_valid = 1'b0;
    d_valid = 1'b0;
    i_addr  = '0;
    d_addr  = '0;
    d_wdata = '0;
    d_wstrb = '0;
    tb_m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Returns at negedge+1 of the cycle in which the selected ready is high.
  task automatic wait_ready(input bit want_d, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      #1;
      if (want_d ? bus.d_ready : bus.i_ready) ok = 1'b1;
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      check(name, outs(), '0);
    end
  endtask

  bit ok;
  byte rr_seq [4];
  byte fp_seq [8];
  int  rr_n, fp_n, dr_pulses;

  initial begin
    //        iv ia     dv da     dw            ds  mr mrd           mv ma     mw            ms  ir dr
    vecs[0]  = '{1, 32'h40, 0, 32'h0,  32'h0,        4'h0, 1, 32'hDEAD0001, 0, 32'h0,  32'h0,        4'h0, 0, 0};
    vecs[1]  = '{1, 32'h40, 1, 32'h80, 32'hCAFEBABE, 4'h3, 0, 32'h00000000, 1, 32'h40, 32'h0,        4'h0, 0, 0};
    vecs[2]  = '{1, 32'h40, 1, 32'h80, 32'hCAFEBABE, 4'h3, 1, 32'h0BADF00D, 1, 32'h40, 32'h0,        4'h0, 1, 0};
    vecs[3]  = '{1, 32'h40, 1, 32'h80, 32'hCAFEBABE, 4'h3, 1, 32'h11111111, 0, 32'h0,  32'h0,        4'h0, 0, 0};
    vecs[4]  = '{1, 32'h40, 1, 32'h80, 32'hCAFEBABE, 4'h3, 0, 32'h22222222, 1, 32'h80, 32'hCAFEBABE, 4'h3, 0, 0};
    vecs[5]  = '{1, 32'h40, 1, 32'h80, 32'hCAFEBABE, 4'h3, 1, 32'h33333333, 1, 32'h80, 32'hCAFEBABE, 4'h3, 0, 1};
    vecs[6]  = '{1, 32'h40, 1, 32'h80, 32'hCAFEBABE, 4'h3, 0, 32'h44444444, 0, 32'h0,  32'h0,        4'h0, 0, 0};
    vecs[7]  = '{0, 32'h40, 1, 32'h80, 32'hCAFEBABE, 4'h3, 0, 32'h0,        1, 32'h40, 32'h0,        4'h0, 0, 0};
    vecs[8]  = '{0, 32'h40, 1, 32'h80, 32'hCAFEBABE, 4'h3, 1, 32'h12345678, 1, 32'h40, 32'h0,        4'h0, 1, 0};
    vecs[9]  = '{0, 32'h0,  0, 32'h0,  32'h0,        4'h0, 0, 32'h0,        0, 32'h0,  32'h0,        4'h0, 0, 0};
    vecs[10] = '{0, 32'h0,  1, 32'h84, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0,  32'h0,        4'h0, 0, 0};
    vecs[11] = '{0, 32'h0,  1, 32'h84, 32'h0,        4'h0, 1, 32'h5555AAAA, 1, 32'h84, 32'h0,        4'h0, 0, 1};
    vecs[12] = '{0, 32'h0,  0, 32'h0,  32'h0,        4'h0, 0, 32'h0,        0, 32'h0,  32'h0,        4'h0, 0, 0};
    vecs[13] = '{0, 32'h0,  0, 32'h0,  32'h0,        4'h0, 1, 32'h0,        0, 32'h0,  32'h0,        4'h0, 0, 0};

    // Reset state and quiet idle
    mode = 1;
    do_reset();
    #1;
    check("reset_outputs", outs(), '0);
    idle_cycles("idle_after_reset", 10);

    // Cycle-by-cycle vector table with directly driven memory handshake
    mode = 0;
    do_reset();
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      i_valid = vecs[v].iv;  i_addr  = vecs[v].ia;
      d_valid = vecs[v].dv;  d_addr  = vecs[v].da;
      d_wdata = vecs[v].dw;  d_wstrb = vecs[v].ds;
      tb_m_ready = vecs[v].mr;  tb_m_rdata = vecs[v].mrd;
      #1;
      check($sformatf("vec%0d_outs", v), outs(),
            {vecs[v].e_mv, vecs[v].e_ma, vecs[v].e_mw, vecs[v].e_ms, vecs[v].e_ir, vecs[v].e_dr});
      check($sformatf("vec%0d_rdata", v), {bus.i_rdata, bus.d_rdata}, {vecs[v].mrd, vecs[v].mrd});
    end

    // Instruction-only fetch from 0x10
    mode = 1;
    do_reset();
    @(negedge clk);
    i_valid = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    #1;
    check("fetch_req", {bus.m_valid, bus.m_addr, bus.m_wstrb, bus.m_wdata}, {1'b1, 32'h10, 4'h0, 32'h0});
    wait_ready(1'b0, 10, ok);
    check("fetch_ready_seen", ok, 1'b1);
    check("fetch_rdata", bus.i_rdata, 32'hA5A50010);
    check("fetch_no_d_ready", bus.d_ready, 1'b0);
    i_valid = 1'b0;

    // Data write 0x12345678 to 0x20
    do_reset();
    @(negedge clk);
    d_valid = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_wstrb = 4'hF;
    wait_ready(1'b1, 10, ok);
    check("write_ready_seen", ok, 1'b1);
    d_valid = 1'b0;
    dr_pulses = 1;
    @(negedge clk);
    #1;
    check("write_turn_gap", bus.m_valid, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.d_ready) dr_pulses++;
    end
    check("write_single_pulse", 32'(dr_pulses), 32'd1);
    check("write_mem8", mem[8], 32'h12345678);

    // Continuous contention: round-robin alternates, fixed priority stays on D
    do_reset();
    rr_n = 0; fp_n = 0;
    @(negedge clk);
    i_valid = 1'b1; i_addr = 32'h100;
    d_valid = 1'b1; d_addr = 32'h200; d_wstrb = 4'h0;
    for (int c = 0; c < 40 && rr_n < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.d_ready) rr_seq[rr_n++] = "D";
      else if (bus.i_ready) rr_seq[rr_n++] = "I";
      if (fp_n < 8 && bus_fp.d_ready) fp_seq[fp_n++] = "D";
      else if (fp_n < 8 && bus_fp.i_ready) fp_seq[fp_n++] = "I";
    end
    check("rr_grant_count", 32'(rr_n), 32'd4);
    check("rr_grant_order", {rr_seq[0], rr_seq[1], rr_seq[2], rr_seq[3]}, {"D", "I", "D", "I"});
    check("fp_grant_count_ge3", fp_n >= 3, 1'b1);
    for (int g = 0; g < fp_n; g++) check($sformatf("fp_grant%0d", g), fp_seq[g], "D");
    i_valid = 1'b0; d_valid = 1'b0;

    // Slave holding ready until valid drops: two back-to-back reads
    mode = 2;
    do_reset();
    @(negedge clk);
    d_valid = 1'b1; d_addr = 32'h0; d_wstrb = 4'h0;
    wait_ready(1'b1, 10, ok);
    check("sticky_rd0_seen", ok, 1'b1);
    check("sticky_rd0_data", bus.d_rdata, 32'hA5A50000);
    d_addr = 32'h4;
    @(negedge clk);
    #1;
    check("sticky_turn", {bus.m_valid, bus.i_ready, bus.d_ready}, 3'b000);
    wait_ready(1'b1, 10, ok);
    check("sticky_rd1_seen", ok, 1'b1);
    check("sticky_rd1_data", bus.d_rdata, 32'hA5A50004);
    d_valid = 1'b0;

    // Asynchronous reset in the middle of a data grant
    mode = 1;
    do_reset();
    @(negedge clk);
    d_valid = 1'b1; d_addr = 32'h8; d_wstrb = 4'h0;
    @(negedge clk);
    #1;
    check("abort_granted", {bus.m_valid, bus.m_addr, bus.d_ready}, {1'b1, 32'h8, 1'b0});
    #1;
    resetn = 1'b0;
    d_valid = 1'b0;
    #1;
    check("abort_async", outs(), '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("abort_in_reset", outs(), '0);
    end
    resetn = 1'b1;
    idle_cycles("idle_after_abort", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vigna_bus_arbiter.md
# vigna_bus_arbiter

Two-to-one memory-port arbiter placed between the vigna core's instruction port (`i_*`) and data port (`d_*`) and a single shared memory port (`m_*`). It lets a unified instruction/data memory serve both ports. It grants one requester at a time, forwards that requester's request to the memory port, and routes the memory's ready/rdata back to the owner. After each completed transfer it inserts one turnaround cycle, so slaves that hold ready high until valid drops work correctly.

## Interface
- `ROUND_ROBIN`, default 1: 1 = alternate the grant on contention; 0 = fixed priority, data port always wins.
- `clk` input, 1 bit: single clock, rising edge.
- `resetn` input, 1 bit: asynchronous, active-low reset.
- `i_valid` input, 1 bit: instruction fetch request. `i_addr` is held stable until `i_ready`.
- `i_addr` input, 32 bits: fetch address.
- `i_ready` output, 1 bit: fetch complete this cycle.
- `i_rdata` output, 32 bits: fetch data. Meaningful only when `i_ready` is high.
- `d_valid` input, 1 bit: data request. `d_addr`, `d_wdata` and `d_wstrb` are held until `d_ready`.
- `d_addr` input, 32 bits; `d_wdata` input, 32 bits; `d_wstrb` input, 4 bits. `d_wstrb` of 0 means a read.
- `d_ready` output, 1 bit; `d_rdata` output, 32 bits. Same meaning as the `i_` pair.
- `m_valid` output, 1 bit: request to memory.
- `m_addr` output, 32 bits; `m_wdata` output, 32 bits; `m_wstrb` output, 4 bits: forwarded request fields.
- `m_ready` input, 1 bit: memory completion.
- `m_rdata` input, 32 bits: memory read data.

## Operation
- States:
  - ARB_IDLE: no owner.
  - ARB_GNT_I: instruction port owns the memory port.
  - ARB_GNT_D: data port owns the memory port.
  - ARB_TURN: one-cycle gap after a completed transfer.
- Arbitration happens in ARB_IDLE and ARB_TURN:
  - Only `i_valid` high: next state is GNT_I.
  - Only `d_valid` high: next state is GNT_D.
  - Neither: stay in or go to IDLE.
  - Both high, ROUND_ROBIN=0: GNT_D.
  - Both high, ROUND_ROBIN=1: grant the port that was not granted last.
- `last_gnt` register:
  - Updated on entry to GNT_I or GNT_D.
  - Reset value is "I", so the first contention after reset goes to D.
- In GNT_x, `m_addr`, `m_wdata` and `m_wstrb` are driven combinationally from port x and `m_valid` is 1.
  - GNT_I forces `m_wstrb` = 0 and `m_wdata` = 0, since the instruction port is read-only.
- In IDLE and TURN, all `m_*` outputs are 0.
- Completion occurs when `m_valid && m_ready` in GNT_x:
  - `x_ready` = 1 in that same cycle.
  - Next state is TURN.
- `i_ready` = `m_ready` AND state==GNT_I. `d_ready` = `m_ready` AND state==GNT_D. The non-owner's ready is never asserted.
- `i_rdata` and `d_rdata` are both continuous copies of `m_rdata`.
- The grant is held until `m_ready` arrives. A requester dropping valid mid-grant is a protocol violation, and the arbiter still waits for `m_ready`.
- `m_ready` seen in IDLE or TURN is ignored and produces no owner ready.

## Timing
- Reset (async assert):
  - State goes to IDLE and `last_gnt` to "I".
  - `m_valid`, `m_addr`, `m_wdata`, `m_wstrb`, `i_ready` and `d_ready` are all 0 immediately.
  - Reset asserted mid-transfer aborts the transfer with no ready pulse.
- Request latency: valid sampled high at edge N puts `m_valid` high from edge N through completion.
- Response latency: `x_ready` has zero cycles of latency from `m_ready`, because the path is combinational.
- Back-to-back transfers: completion at edge K is followed by `m_valid` low for exactly the cycle after edge K (TURN). The next grant's `m_valid` rises at edge K+1.
- Throughput: with a one-cycle slave, the arbiter sustains at most one transfer per 3 cycles.
- Contention stays fair under ROUND_ROBIN=1: with both ports continuously requesting, grants alternate D, I, D, I …

## Structure
- Package `vigna_arb_pkg` holds:
  - State enum `arb_state_t`: ARB_IDLE, ARB_GNT_I, ARB_GNT_D, ARB_TURN.
  - Owner constants ARB_OWN_I and ARB_OWN_D for `last_gnt`.
- A single flat module with no sub-module. The round-robin pick is a small combinational function in the package (`arb_pick`).

## Test plan
- After reset, with neither valid high: all `m_*` outputs and both readies stay 0 for 10 cycles.
- I-only fetch from 0x0000_0010 with one-cycle memory:
  - `m_addr` = 0x10 and `m_wstrb` = 0.
  - `i_ready` pulses with `i_rdata` = mem[4].
  - `d_ready` stays 0.
- D write 0x1234_5678 to 0x20 with strobe 0xF:
  - Memory word 8 becomes 0x1234_5678.
  - `d_ready` pulses once, followed by one cycle of `m_valid` = 0.
- Both ports valid continuously with ROUND_ROBIN=1:
  - Grant order is D, I, D, I.
  - With ROUND_ROBIN=0, D is granted every time while `d_valid` is held.
- Slave holding ready high until valid drops: two consecutive D reads of 0x0 and 0x4 return the correct distinct data, and no spurious ready occurs during TURN.
- `resetn` pulled low while `m_valid` is high in GNT_D, before `m_ready`: `m_valid` drops asynchronously and no `d_ready` is produced. After release, IDLE behaviour matches the first test.
